jt900h_bus: RTL and testbench



---
 rtl/jt900h_bus.sv | 131 +++++++++++++
 tb/tb_jt900h_bus.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_bus.sv
// Memory bridge for the jt900h core: decodes each bus cycle to I/O, work RAM
// or ROM and paces the core with a one-clk cpu_cen per completed access.
module jt900h_bus #(
  parameter logic [23:0] RAM_BASE = 24'h004000,
  parameter int          RAM_AW   = 14,
  parameter int          TIMEOUT  = 255
)(
  input  logic              rst,
  input  logic              clk,
  input  logic              cen_in,
  output logic              cpu_cen,
  input  logic [23:0]       cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic [1:0]        cpu_we,
  output logic [15:0]       cpu_dout,
  output logic [RAM_AW-2:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic [1:0]        ram_we,
  input  logic [15:0]       ram_dout,
  output logic [22:0]       rom_addr,
  output logic              rom_cs,
  input  logic [15:0]       rom_data,
  input  logic              rom_ok,
  output logic [7:0]        io_addr,
  output logic [15:0]       io_din,
  output logic [1:0]        io_we,
  output logic              io_cs,
  input  logic [15:0]       io_dout,
  output logic              bus_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, IO, RAM0, RAM1, ROM, ACK} state_t;

  state_t        st;
  logic [1:0]    we_l;
  logic [WW-1:0] wait_cnt;
  logic          ram_hit;
  logic          rom_limit;

  assign ram_hit   = cpu_addr[23:RAM_AW] == RAM_BASE[23:RAM_AW];
  assign rom_limit = wait_cnt == WW'(TIMEOUT - 1);

  // Strobes are registered on entry to each state so they are valid for the
  // whole clk the state lasts; cpu_cen is set on the edge that enters ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      we_l     <= 2'b00;
      wait_cnt <= '0;
      cpu_cen  <= 1'b0;
      cpu_dout <= 16'h0000;
      ram_addr <= '0;
      ram_din  <= 16'h0000;
      ram_we   <= 2'b00;
      rom_addr <= 23'h0;
      rom_cs   <= 1'b0;
      io_addr  <= 8'h00;
      io_din   <= 16'h0000;
      io_we    <= 2'b00;
      io_cs    <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      cpu_cen <= 1'b0;
      case (st)
        IDLE: begin
          if (cen_in) begin
            we_l <= cpu_we;
            if (cpu_addr[23:8] == 16'h0000) begin
              st      <= IO;
              io_cs   <= 1'b1;
              io_addr <= cpu_addr[7:0];
              io_din  <= cpu_din;
              io_we   <= cpu_we;
            end else if (ram_hit) begin
              st       <= RAM0;
              ram_addr <= cpu_addr[RAM_AW-1:1];
              ram_din  <= cpu_din;
              ram_we   <= cpu_we;
            end else begin
              // ROM writes still spend one clk here but never raise rom_cs
              st       <= ROM;
              rom_addr <= cpu_addr[23:1];
              rom_cs   <= cpu_we == 2'b00;
              wait_cnt <= '0;
            end
          end
        end
        IO: begin
          io_cs <= 1'b0;
          io_we <= 2'b00;
          if (we_l == 2'b00) cpu_dout <= io_dout;
          st      <= ACK;
          cpu_cen <= 1'b1;
        end
        RAM0: begin
          ram_we <= 2'b00;
          st     <= RAM1;
        end
        RAM1: begin
          if (we_l == 2'b00) cpu_dout <= ram_dout;
          st      <= ACK;
          cpu_cen <= 1'b1;
        end
        ROM: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (we_l != 2'b00) begin
            st      <= ACK;
            cpu_cen <= 1'b1;
          end else if (wait_cnt != '0 && rom_ok) begin
            // ok seen in the first ROM clk may be left over from a prior access
            cpu_dout <= rom_data;
            rom_cs   <= 1'b0;
            st       <= ACK;
            cpu_cen  <= 1'b1;
          end else if (rom_limit) begin
            cpu_dout <= 16'hFFFF;
            bus_err  <= 1'b1;
            rom_cs   <= 1'b0;
            st       <= ACK;
            cpu_cen  <= 1'b1;
          end
        end
        ACK:     st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_bus.sv
// Randomized bench for jt900h_bus: a transaction-level model predicts the
// latency, read data and error flag of every access.
module tb_jt900h_bus;

  localparam int TIMEOUT = 255;

  logic        rst, clk, cen_in, cpu_cen;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din, cpu_dout;
  logic [1:0]  cpu_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic [1:0]  ram_we;
  logic [22:0] rom_addr;
  logic        rom_cs, rom_ok;
  logic [15:0] rom_data;
  logic [7:0]  io_addr;
  logic [15:0] io_din, io_dout;
  logic [1:0]  io_we;
  logic        io_cs, bus_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] dev_mem [0:8191];
  logic [15:0] ref_mem [0:8191];
  logic [15:0] exp_dout;
  logic        exp_err;

  jt900h_bus dut (
    .rst(rst), .clk(clk), .cen_in(cen_in), .cpu_cen(cpu_cen),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .io_addr(io_addr), .io_din(io_din), .io_we(io_we), .io_cs(io_cs),
    .io_dout(io_dout), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous work RAM attached to the bridge
  always @(posedge clk) begin
    if (ram_we[0]) dev_mem[ram_addr][7:0]  <= ram_din[7:0];
    if (ram_we[1]) dev_mem[ram_addr][15:8] <= ram_din[15:8];
    ram_dout <= dev_mem[ram_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One CPU access. rom_k < 0 means rom_ok never rises; otherwise rom_ok is
  // high from ROM clk index rom_k (0-based) on. Called in mid-clk of an IDLE clk.
  task automatic apply_stimulus(input logic [23:0] addr, input logic [15:0] din,
                                input logic [1:0] we, input int rom_k,
                                input bit ok_early, input logic [15:0] dev_data);
    bit is_io, is_ram, is_rom, done;
    int n, exp_lat, eff, io_cnt;
    is_io  = addr[23:8] == 16'h0;
    is_ram = !is_io && addr[23:14] == 10'h001;
    is_rom = !is_io && !is_ram;
    if (is_io) begin
      exp_lat = 2;
      if (we == 2'b00) exp_dout = dev_data;
    end else if (is_ram) begin
      exp_lat = 3;
      if (we == 2'b00) exp_dout = ref_mem[addr[13:1]];
      if (we[0]) ref_mem[addr[13:1]][7:0]  = din[7:0];
      if (we[1]) ref_mem[addr[13:1]][15:8] = din[15:8];
    end else if (we != 2'b00) begin
      exp_lat = 2;
    end else begin
      eff = (rom_k < 1) ? 1 : rom_k;
      if (rom_k >= 0 && eff <= TIMEOUT - 1) begin
        exp_lat  = 2 + eff;
        exp_dout = dev_data;
      end else begin
        exp_lat  = TIMEOUT + 1;
        exp_dout = 16'hFFFF;
        exp_err  = 1'b1;
      end
    end

    cpu_addr = addr; cpu_din = din; cpu_we = we; cen_in = 1'b1;
    io_dout  = dev_data;
    rom_ok   = ok_early;
    rom_data = ~dev_data;
    n = 0; done = 0; io_cnt = 0;
    while (!done && n < TIMEOUT + 40) begin
      @(negedge clk);
      n++;
      if (io_cs) io_cnt++;
      if (n == 1) begin
        cen_in   = 1'b0;
        cpu_addr = 24'($urandom);
        cpu_din  = 16'($urandom);
        cpu_we   = 2'($urandom);
        if (is_io) begin
          check_output("io_addr", io_addr, addr[7:0]);
          check_output("io_din", io_din, din);
          check_output("io_we", io_we, we);
        end
        if (is_ram) begin
          check_output("ram_addr", ram_addr, addr[13:1]);
          check_output("ram_din", ram_din, din);
          check_output("ram_we", ram_we, we);
        end
        if (is_rom) begin
          check_output("rom_cs_first", rom_cs, we == 2'b00);
          if (we == 2'b00) check_output("rom_addr", rom_addr, addr[23:1]);
        end else begin
          check_output("rom_cs_idle", rom_cs, 1'b0);
        end
      end
      if (is_ram && n == 2) check_output("ram_we_off", ram_we, 2'b00);
      if (cpu_cen) begin
        done = 1;
        check_output("latency", n, exp_lat);
        check_output("cpu_dout", cpu_dout, exp_dout);
        check_output("bus_err", bus_err, exp_err);
        check_output("rom_cs_ack", rom_cs, 1'b0);
      end else begin
        rom_ok   = rom_k >= 0 && (n - 1) >= rom_k;
        rom_data = (n - 1 >= 1) ? dev_data : ~dev_data;
      end
    end
    if (!done) check_output("latency_bound", n, exp_lat);
    check_output("io_cs_clks", io_cnt, is_io ? 1 : 0);
    rom_ok = 1'b0;
    @(negedge clk);
    check_output("cen_pulse", cpu_cen, 1'b0);
  endtask

  initial begin
    logic [23:0] a;
    logic [1:0]  w;
    int          cen_seen;
    for (int i = 0; i < 8192; i++) begin
      dev_mem[i] = 16'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    rst = 1'b1; cen_in = 1'b0; cpu_addr = 24'h0; cpu_din = 16'h0; cpu_we = 2'b00;
    rom_ok = 1'b0; rom_data = 16'h0; io_dout = 16'h0;
    exp_dout = 16'h0000; exp_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    cen_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_cen) cen_seen++;
    end
    check_output("reset_cen", cen_seen, 0);
    check_output("reset_dout", cpu_dout, 16'h0);
    check_output("reset_strobes", {ram_we, io_we, io_cs, rom_cs, bus_err}, 7'h0);
    check_output("reset_addr", {rom_addr, io_addr}, 31'h0);
    check_output("reset_ram", {ram_addr, ram_din, io_din}, 45'h0);

    apply_stimulus(24'h000020, 16'h0000, 2'b00, 0, 1'b0, 16'h1234);
    check_output("io_1234", cpu_dout, 16'h1234);
    apply_stimulus(24'h000044, 16'h5A5A, 2'b11, 0, 1'b0, 16'h9999);
    apply_stimulus(24'h004010, 16'hBEEF, 2'b01, 0, 1'b0, 16'h0);
    apply_stimulus(24'h004010, 16'h0000, 2'b00, 0, 1'b0, 16'h0);
    check_output("ram_lo_byte", cpu_dout[7:0], 8'hEF);
    apply_stimulus(24'h200000, 16'h0000, 2'b00, 0, 1'b1, 16'hC0DE);
    apply_stimulus(24'h300010, 16'h1111, 2'b10, 0, 1'b0, 16'h0);
    apply_stimulus(24'h200100, 16'h0000, 2'b00, 4, 1'b0, 16'h7E57);
    apply_stimulus(24'h200200, 16'h0000, 2'b00, TIMEOUT - 1, 1'b0, 16'hA11E);
    apply_stimulus(24'h200300, 16'h0000, 2'b00, TIMEOUT, 1'b0, 16'h0BAD);
    apply_stimulus(24'h200400, 16'h0000, 2'b00, -1, 1'b0, 16'h0BAD);
    apply_stimulus(24'h000021, 16'h0000, 2'b00, 0, 1'b0, 16'h4321);

    // Reset in the middle of a ROM wait
    cpu_addr = 24'h200000; cpu_we = 2'b00; cen_in = 1'b1; rom_ok = 1'b0;
    @(negedge clk);
    cen_in = 1'b0;
    repeat (8) @(negedge clk);
    check_output("rom_cs_wait", rom_cs, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_rom_cs", rom_cs, 1'b0);
    check_output("rst_bus_err", bus_err, 1'b0);
    exp_err = 1'b0; exp_dout = 16'h0000;
    cen_seen = 0;
    repeat (5) begin
      if (cpu_cen) cen_seen++;
      @(negedge clk);
    end
    check_output("rst_no_cen", cen_seen, 0);
    apply_stimulus(24'h000020, 16'h0000, 2'b00, 0, 1'b0, 16'h2468);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0:       a = {16'h0000, 8'($urandom)};
        1:       a = {10'h001, 8'h00, 6'($urandom)};
        default: a = {9'($urandom_range(1, 511)), 15'($urandom)};
      endcase
      w = ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00;
      apply_stimulus(a, 16'($urandom), w, $urandom_range(0, 6),
                     $urandom_range(0, 1) == 1, 16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        check_output("idle_cen", cpu_cen, 1'b0);
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
